net_meta_slice_array_gen: RTL

Parametrised pipelining array for the network-stack control/meta path between the user region and the network stack. It carries N_CH independent valid/ready channels and one free-running status lane through N_STAGES register stages. Each handshaked stage is a full-throughput skid stage, so timing is cut on data, valid and ready. It adds a synchronous flush and generic widths, which replaces the fixed per-signal slice instances used for ARP, IP/MAC setting, drop and stats.

---
 rtl/net_meta_slice_array_gen.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/net_meta_slice_array_gen.sv
// net_meta_slice_array_gen
//   Pipelining array for the network-stack control/meta path. Carries N_CH
//   independent valid/ready channels plus one free-running status lane
//   through N_STAGES register stages. Every handshaked stage is a
//   full-throughput skid stage (main + skid register), so data, valid and
//   ready are all registered at every stage boundary.
//
// Ports
//   aclk, aresetn      clock, asynchronous active-low reset
//   s_flush            synchronous flush of all in-flight channel words
//   s_valid/s_ready    per-channel input handshake
//   s_data             channel i at [i*DATA_BITS +: DATA_BITS]
//   m_valid/m_ready    per-channel output handshake
//   m_data             same packing as s_data
//   s_stat/m_stat      status lane, m_stat = s_stat delayed N_STAGES cycles
//   m_occ, m_occ_max   (only with SLICE_OCC_EN) per-channel occupancy and
//                      high-watermark, channel i at [i*OCC_BITS +: OCC_BITS]
//
// Optional feature macro: SLICE_OCC_EN
//
// N_STAGES = 0 degenerates to a wire: flush is ignored and the occupancy
// outputs (if present) are tied to 0.

module net_meta_slice_array_gen #(
    parameter int N_CH      = 4,
    parameter int DATA_BITS = 64,
    parameter int STAT_BITS = 512,
    parameter int N_STAGES  = 2,
    // Occupancy ranges 0..2*N_STAGES; kept at least 1 bit wide for N_STAGES=0.
    localparam int OCC_BITS = (N_STAGES == 0) ? 1 : $clog2(2*N_STAGES+1)
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      s_flush,
    input  logic [N_CH-1:0]           s_valid,
    output logic [N_CH-1:0]           s_ready,
    input  logic [N_CH*DATA_BITS-1:0] s_data,
    output logic [N_CH-1:0]           m_valid,
    input  logic [N_CH-1:0]           m_ready,
    output logic [N_CH*DATA_BITS-1:0] m_data,
    input  logic [STAT_BITS-1:0]      s_stat,
`ifdef SLICE_OCC_EN
    output logic [N_CH*OCC_BITS-1:0]  m_occ,
    output logic [N_CH*OCC_BITS-1:0]  m_occ_max,
`endif
    output logic [STAT_BITS-1:0]      m_stat
);

    generate
        if (N_STAGES == 0) begin : g_pass
            assign m_valid = s_valid;
            assign s_ready = m_ready;
            assign m_data  = s_data;
            assign m_stat  = s_stat;
`ifdef SLICE_OCC_EN
            assign m_occ     = '0;
            assign m_occ_max = '0;
`endif
        end else begin : g_pipe
            for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
                // v/r/d[k] is the interface into stage k; index N_STAGES is the output.
                logic [N_STAGES:0]                v;
                logic [N_STAGES:0]                r;
                logic [N_STAGES:0][DATA_BITS-1:0] d;

                assign v[0]       = s_valid[ch];
                assign d[0]       = s_data[ch*DATA_BITS +: DATA_BITS];
                assign s_ready[ch] = r[0];
                assign r[N_STAGES] = m_ready[ch];
                assign m_valid[ch] = v[N_STAGES];
                assign m_data[ch*DATA_BITS +: DATA_BITS] = d[N_STAGES];

                for (genvar k = 0; k < N_STAGES; k++) begin : g_st
                    logic                 mv, sv;
                    logic [DATA_BITS-1:0] md, sd;
                    logic                 acc, drn;

                    // Ready depends only on the registered skid flag, so no
                    // combinational ready path spans more than one stage.
                    assign r[k]   = ~sv;
                    assign acc    = v[k] & ~sv;
                    assign drn    = mv & r[k+1];
                    assign v[k+1] = mv;
                    assign d[k+1] = md;

                    always_ff @(posedge aclk or negedge aresetn) begin
                        if (!aresetn) begin
                            mv <= 1'b0;
                            sv <= 1'b0;
                            md <= '0;
                            sd <= '0;
                        end else if (s_flush) begin
                            mv <= 1'b0;
                            sv <= 1'b0;
                        end else if (sv) begin
                            // Full stage: nothing accepted; refill main from skid.
                            if (drn) begin
                                md <= sd;
                                sv <= 1'b0;
                            end
                        end else if (acc) begin
                            if (!mv || drn) begin
                                md <= d[k];
                                mv <= 1'b1;
                            end else begin
                                sd <= d[k];
                                sv <= 1'b1;
                            end
                        end else if (drn) begin
                            mv <= 1'b0;
                        end
                    end
                end

`ifdef SLICE_OCC_EN
                logic [OCC_BITS-1:0] occ_q, occ_max_q, occ_nxt;
                logic                in_hs, out_hs;

                assign in_hs  = v[0] & r[0];
                assign out_hs = v[N_STAGES] & r[N_STAGES];

                always_comb begin
                    occ_nxt = occ_q;
                    if (in_hs && !out_hs)
                        occ_nxt = occ_q + OCC_BITS'(1);
                    else if (out_hs && !in_hs)
                        occ_nxt = occ_q - OCC_BITS'(1);
                end

                // Watermark tracks the next value so it never trails m_occ.
                always_ff @(posedge aclk or negedge aresetn) begin
                    if (!aresetn) begin
                        occ_q     <= '0;
                        occ_max_q <= '0;
                    end else if (s_flush) begin
                        occ_q <= '0;
                    end else begin
                        occ_q <= occ_nxt;
                        if (occ_nxt > occ_max_q)
                            occ_max_q <= occ_nxt;
                    end
                end

                assign m_occ[ch*OCC_BITS +: OCC_BITS]     = occ_q;
                assign m_occ_max[ch*OCC_BITS +: OCC_BITS] = occ_max_q;
`endif
            end

            // Status lane: unconditional shift, untouched by flush.
            logic [N_STAGES-1:0][STAT_BITS-1:0] stat_q;

            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    stat_q <= '0;
                end else begin
                    stat_q[0] <= s_stat;
                    for (int k = 1; k < N_STAGES; k++)
                        stat_q[k] <= stat_q[k-1];
                end
            end

            assign m_stat = stat_q[N_STAGES-1];
        end
    endgenerate

endmodule
